// File: rtl/seg_scan_counter.sv
// Debounced two-button BCD event counter (0000-9999) time-multiplexed onto a nibble bus with active-low anodes.
// Latency: count updates DEB_CYCLES+3 cycles after a stable press; display outputs are registered one cycle behind index/count.
// Backpressure: none; button presses while en=0 are dropped, and the scan runs freely.
module seg_scan_counter #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_clr,
    input  logic        en,
    output logic [3:0]  nibble,
    output logic [3:0]  digit_n,
    output logic        dp,
    output logic [15:0] count,
    output logic        ovf
);
    localparam int DW  = $clog2(DEB_CYCLES + 1);
    localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Index 0 is the increment button, index 1 is the clear button.
    logic [1:0]    sync1, sync2, stb, stb_d, hold;
    logic [1:0]    warm;
    logic [DW-1:0] dcnt [2];
    logic          inc_p, clr_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            stb   <= '0;
            stb_d <= '0;
            warm  <= '0;
            hold  <= 2'b11;
            for (int b = 0; b < 2; b++) dcnt[b] <= '0;
        end else begin
            sync1 <= {btn_clr, btn_inc};
            sync2 <= sync1;
            stb_d <= stb;
            warm  <= {warm[0], 1'b1};
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != stb[b]) begin
                    if (dcnt[b] == DW'(DEB_CYCLES)) begin
                        stb[b]  <= sync2[b];
                        dcnt[b] <= '0;
                    end else begin
                        dcnt[b] <= dcnt[b] + 1'b1;
                    end
                end else begin
                    dcnt[b] <= '0;
                end
                // A button held across reset stays muted until it is seen released.
                if (warm[1] && !sync2[b]) hold[b] <= 1'b0;
            end
        end
    end

    assign inc_p = stb[0] & ~stb_d[0] & ~hold[0];
    assign clr_p = stb[1] & ~stb_d[1] & ~hold[1];

    logic [15:0] count_q, count_nxt, inc_val;
    logic        ovf_q, ovf_nxt, wrap;

    always_comb begin
        inc_val = count_q;
        wrap    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (wrap) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    inc_val[i*4 +: 4] = 4'd0;
                end else begin
                    inc_val[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    wrap = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_nxt = count_q;
        ovf_nxt   = 1'b0;
        if (clr_p) begin
            count_nxt = 16'h0000;
        end else if (inc_p && en) begin
            count_nxt = inc_val;
            ovf_nxt   = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    logic [SDW-1:0] div;
    logic [1:0]     idx;
    logic [3:0]     dsel;
    logic           blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= 2'd0;
        end else if (div == SDW'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Blank a slot when its digit and every digit above it are zero; slot 0 always shows.
    assign dsel  = count_q[{idx, 2'b00} +: 4];
    assign blank = (idx != 2'd0) && ((count_q >> {idx, 2'b00}) == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_n <= 4'b1110;
            nibble  <= 4'h0;
            dp      <= 1'b1;
        end else begin
            digit_n <= blank ? 4'b1111 : ~(4'b0001 << idx);
            nibble  <= blank ? 4'h0 : dsel;
            dp      <= ~((idx == 2'd0) && !en);
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed bench for seg_scan_counter with DEB_CYCLES=4 and SCAN_DIV=4.
module tb_seg_scan_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_inc = 1'b0;
    logic        btn_clr = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  nibble, digit_n;
    logic        dp, ovf;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    seg_scan_counter #(.SCAN_DIV(4), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_clr(btn_clr), .en(en),
        .nibble(nibble), .digit_n(digit_n), .dp(dp), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: 7 cycles high, 7 low.
    task automatic press(input logic i, input logic c);
        btn_inc = i;
        btn_clr = c;
        cyc(7);
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        cyc(7);
    endtask

    logic [3:0] exp_dn [4];
    logic [3:0] exp_nb [4];
    int         waited;
    int         dp_low;

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_digit_n", 32'(digit_n), 32'hE);
        chk("rst_nibble", 32'(nibble), 32'h0);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);

        // 3-cycle glitch is rejected.
        btn_inc = 1'b1;
        cyc(3);
        btn_inc = 1'b0;
        cyc(12);
        chk("glitch_count", 32'(count), 32'h0);

        // Held 10 cycles: one increment, exactly 7 cycles after the first sampling edge.
        btn_inc = 1'b1;
        cyc(7);
        chk("lat_before", 32'(count), 32'h0);
        cyc(1);
        chk("lat_at", 32'(count), 32'h1);
        cyc(2);
        btn_inc = 1'b0;
        cyc(10);
        chk("held_once", 32'(count), 32'h1);

        for (int k = 0; k < 41; k++) press(1'b1, 1'b0);
        chk("count_42", 32'(count), 32'h0042);

        // Scan with 0042: slots 1110(2),1101(4),1111,1111, each held 4 cycles.
        exp_dn[0] = 4'b1101; exp_nb[0] = 4'h4;
        exp_dn[1] = 4'b1111; exp_nb[1] = 4'h0;
        exp_dn[2] = 4'b1111; exp_nb[2] = 4'h0;
        exp_dn[3] = 4'b1110; exp_nb[3] = 4'h2;
        waited = 0;
        while (digit_n !== 4'b1101 && waited < 40) begin
            cyc(1);
            waited++;
        end
        chk("scan_found", 32'(waited < 40), 32'h1);
        for (int i = 0; i < 32; i++) begin
            chk("scan_digit_n", 32'(digit_n), 32'(exp_dn[(i / 4) % 4]));
            chk("scan_nibble", 32'(nibble), 32'(exp_nb[(i / 4) % 4]));
            chk("scan_dp", 32'(dp), 32'h1);
            cyc(1);
        end

        // Carry chain.
        for (int k = 0; k < 57; k++) press(1'b1, 1'b0);
        chk("count_99", 32'(count), 32'h0099);
        press(1'b1, 1'b0);
        chk("carry_100", 32'(count), 32'h0100);
        for (int k = 0; k < 899; k++) press(1'b1, 1'b0);
        chk("count_999", 32'(count), 32'h0999);
        press(1'b1, 1'b0);
        chk("carry_1000", 32'(count), 32'h1000);

        // Paused: increments dropped, dp low only in slot 0.
        en = 1'b0;
        press(1'b1, 1'b0);
        chk("en0_hold", 32'(count), 32'h1000);
        dp_low = 0;
        for (int i = 0; i < 16; i++) begin
            if (dp === 1'b0) begin
                dp_low++;
                chk("dp_slot0", 32'(digit_n), 32'hE);
            end
            cyc(1);
        end
        chk("dp_low_cycles", 32'(dp_low), 32'd4);
        en = 1'b1;
        press(1'b1, 1'b0);
        chk("en0_not_queued", 32'(count), 32'h1001);

        // Clear works regardless of en.
        en = 1'b0;
        press(1'b0, 1'b1);
        chk("clr_en0", 32'(count), 32'h0);
        en = 1'b1;

        // Wrap 9999 -> 0000 with a single-cycle ovf.
        force dut.count_q = 16'h9999;
        cyc(1);
        release dut.count_q;
        cyc(1);
        chk("preload_9999", 32'(count), 32'h9999);
        btn_inc = 1'b1;
        cyc(7);
        chk("wrap_before", 32'(count), 32'h9999);
        chk("wrap_ovf_before", 32'(ovf), 32'h0);
        cyc(1);
        chk("wrap_count", 32'(count), 32'h0);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        cyc(1);
        chk("wrap_ovf_drop", 32'(ovf), 32'h0);
        btn_inc = 1'b0;
        cyc(10);

        // Simultaneous clear and increment: clear wins, no ovf.
        force dut.count_q = 16'h9999;
        cyc(1);
        release dut.count_q;
        cyc(1);
        btn_inc = 1'b1;
        btn_clr = 1'b1;
        cyc(8);
        chk("both_count", 32'(count), 32'h0);
        chk("both_ovf", 32'(ovf), 32'h0);
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        cyc(10);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("pre_reset_count", 32'(count), 32'h2);

        // Reset mid-debounce with the button held through release.
        btn_inc = 1'b1;
        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_digit_n", 32'(digit_n), 32'hE);
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        chk("held_after_rst", 32'(count), 32'h0);
        btn_inc = 1'b0;
        cyc(10);
        chk("release_after_rst", 32'(count), 32'h0);
        btn_inc = 1'b1;
        cyc(7);
        chk("repress_before", 32'(count), 32'h0);
        cyc(1);
        chk("repress_at", 32'(count), 32'h1);
        btn_inc = 1'b0;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
